// File: rtl/lfsr_burst_arb.sv
// -----------------------------------------------------------------------------
// lfsr_burst_arb
//
// Round-robin scheduler that shares one 16-bit Fibonacci LFSR between two
// requesters. The granted requester receives a burst of req_lenN samples on a
// valid/ready stream. The LFSR only advances on an accepted transfer, so the
// sample sequence seen by the two consumers interleaves deterministically,
// burst by burst. LFSR state carries over from one burst to the next.
//
// Optional feature (macro LFSR_ARB_CHKSUM_EN):
//   Adds output burst_chksum, the XOR of every sample accepted in the current
//   burst. It is cleared at grant, is complete in the DONE cycle, and holds
//   until the next grant. With the macro undefined, neither the port nor the
//   accumulator exists.
//
// Parameters:
//   LEN_W      width of the burst-length request fields
//   SEED_INIT  LFSR state after reset
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   req[1:0]      req[i]=1: requester i wants a burst (hold until done[i])
//   req_len0/1    burst length per requester, sampled at grant
//   seed_load     load seed_in into the LFSR (only honoured in IDLE)
//   seed_in       seed value (0 is replaced by 16'h0001)
//   out_valid     out_data holds a valid sample
//   out_ready     consumer accepts the sample
//   out_data      current LFSR state (0 while no sample is offered)
//   out_id        index of the granted requester
//   grant[1:0]    one-hot grant, held for the whole burst
//   done[1:0]     one-cycle pulse for the requester whose burst finished
//   burst_chksum  (LFSR_ARB_CHKSUM_EN only) XOR of accepted samples
// -----------------------------------------------------------------------------
module lfsr_burst_arb #(
    parameter int          LEN_W     = 8,
    parameter logic [15:0] SEED_INIT = 16'h0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    input  logic             seed_load,
    input  logic [15:0]      seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_id,
    output logic [1:0]       grant,
    output logic [1:0]       done
`ifdef LFSR_ARB_CHKSUM_EN
    ,
    output logic [15:0]      burst_chksum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic             rr_ptr;
    logic [LEN_W-1:0] count;

    logic             sel;
    logic [LEN_W-1:0] sel_len;
    logic             xfer;

    // Taps 16,14,13,11 (bits 15,13,12,10): maximal-length polynomial.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed maps to 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Prefer the requester rr_ptr points at; fall back to the other one.
    assign sel     = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign sel_len = sel ? req_len1 : req_len0;
    assign xfer    = out_valid & out_ready;

    // Only drive the LFSR state out while a sample is actually offered.
    assign out_data = out_valid ? lfsr : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= SEED_INIT;
            rr_ptr    <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            grant     <= 2'b00;
            done      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    // A seed loaded in the grant cycle is the first sample of that burst.
                    if (seed_load) begin
                        lfsr <= seed_fix(seed_in);
                    end
                    if (|req) begin
                        out_id <= sel;
                        grant  <= onehot(sel);
                        count  <= sel_len;
                        if (sel_len == '0) begin
                            // Empty burst: skip RUN, still report completion.
                            state <= DONE;
                            done  <= onehot(sel);
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (xfer) begin
                        lfsr  <= lfsr_next(lfsr);
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= onehot(out_id);
                        end
                    end
                end

                DONE: begin
                    done   <= 2'b00;
                    grant  <= 2'b00;
                    rr_ptr <= ~out_id;
                    state  <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    grant     <= 2'b00;
                    done      <= 2'b00;
                end
            endcase
        end
    end

`ifdef LFSR_ARB_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_chksum <= 16'h0000;
        end else if (state == IDLE && (|req)) begin
            burst_chksum <= 16'h0000;
        end else if (state == RUN && xfer) begin
            burst_chksum <= burst_chksum ^ lfsr;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_burst_arb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lfsr_burst_arb. Expected samples are pushed to a
// queue when a burst is requested and popped by a monitor on every accepted
// transfer.
// -----------------------------------------------------------------------------
module tb_lfsr_burst_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [7:0]  req_len0;
    logic [7:0]  req_len1;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_id;
    logic [1:0]  grant;
    logic [1:0]  done;
`ifdef LFSR_ARB_CHKSUM_EN
    logic [15:0] burst_chksum;
`endif

    always #5 clk = ~clk;

    lfsr_burst_arb #(
        .LEN_W     (8),
        .SEED_INIT (16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len0  (req_len0),
        .req_len1  (req_len1),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .grant     (grant),
        .done      (done)
`ifdef LFSR_ARB_CHKSUM_EN
        ,
        .burst_chksum (burst_chksum)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic id, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({id, m_lfsr});
            m_lfsr = model_step(m_lfsr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a done pulse; timing out leaves done==0 and fails.
    task automatic wait_done(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 100);
        chk(tag, {30'b0, done}, {30'b0, exp});
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                chk("xfer_data",  {16'b0, out_data}, {16'b0, e.data});
                chk("xfer_id",    {31'b0, out_id},   {31'b0, e.id});
                chk("xfer_grant", {30'b0, grant},    {30'b0, (e.id ? 2'b10 : 2'b01)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 2'b00; req_len0 = 8'd0; req_len1 = 8'd0;
        seed_load = 1'b0; seed_in = 16'h0000; out_ready = 1'b0;
        m_lfsr = 16'h0001;
        repeat (3) step();

        // Reset state
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data",  {16'b0, out_data},  32'd0);
        chk("rst_id",    {31'b0, out_id},    32'd0);
        chk("rst_grant", {30'b0, grant},     32'd0);
        chk("rst_done",  {30'b0, done},      32'd0);
        chk("rst_lfsr",  {16'b0, dut.lfsr},  32'h0001);
        reset = 1'b0;
        step();

        // Test 1: single burst of 3 from requester 0
        seed_load = 1'b1; seed_in = 16'h0001; req = 2'b01; req_len0 = 8'd3; out_ready = 1'b1;
        m_lfsr = 16'h0001;
        push_burst(1'b0, 3);
        step();
        seed_load = 1'b0;
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_grant", {30'b0, grant},     32'd1);
        wait_done("t1_done", 2'b01);
        chk("t1_lfsr", {16'b0, dut.lfsr}, 32'h0008);
`ifdef LFSR_ARB_CHKSUM_EN
        chk("t1_chksum", {16'b0, burst_chksum}, 32'h0007);
`endif
        step();
        req = 2'b00;
        chk("t1_done_pulse", {30'b0, done},      32'd0);
        chk("t1_grant_clr",  {30'b0, grant},     32'd0);
        chk("t1_valid_clr",  {31'b0, out_valid}, 32'd0);

        // Test 2: both requesting, alternation 0,1,0
        reset = 1'b1;
        step();
        reset = 1'b0;
        seed_load = 1'b1; seed_in = 16'h0001; req = 2'b11; req_len0 = 8'd2; req_len1 = 8'd2;
        m_lfsr = 16'h0001;
        push_burst(1'b0, 2);
        push_burst(1'b1, 2);
        push_burst(1'b0, 2);
        step();
        seed_load = 1'b0;
        wait_done("t2_done_a", 2'b01);
`ifdef LFSR_ARB_CHKSUM_EN
        chk("t2_chksum_a", {16'b0, burst_chksum}, 32'h0003);
`endif
        wait_done("t2_done_b", 2'b10);
`ifdef LFSR_ARB_CHKSUM_EN
        chk("t2_chksum_b", {16'b0, burst_chksum}, 32'h000C);
`endif
        wait_done("t2_done_c", 2'b01);
`ifdef LFSR_ARB_CHKSUM_EN
        chk("t2_chksum_c", {16'b0, burst_chksum}, 32'h0030);
`endif
        step();
        req = 2'b00;
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        step();

        // Test 3: stall with out_ready 1,0,0,1 on a len=2 burst (requester 1)
        req = 2'b10; req_len1 = 8'd2; out_ready = 1'b1;
        push_burst(1'b1, 2);
        step();
        req = 2'b00;
        step();
        out_ready = 1'b0;
        chk("t3_stall_data1", {16'b0, out_data},  32'h0080);
        chk("t3_stall_valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("t3_stall_data2", {16'b0, out_data}, 32'h0080);
        chk("t3_stall_lfsr",  {16'b0, dut.lfsr}, 32'h0080);
        step();
        out_ready = 1'b1;
        wait_done("t3_done", 2'b10);
        chk("t3_lfsr", {16'b0, dut.lfsr}, {16'b0, m_lfsr});
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        step();

        // Test 4: zero-length burst
        req = 2'b01; req_len0 = 8'd0;
        step();
        chk("t4_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_done",  {30'b0, done},      32'd1);
        chk("t4_grant", {30'b0, grant},     32'd1);
        step();
        req = 2'b00;
        chk("t4_done_pulse", {30'b0, done},     32'd0);
        chk("t4_lfsr",       {16'b0, dut.lfsr}, {16'b0, m_lfsr});
        step();

        // Test 5: zero seed in IDLE, seed_load ignored during RUN
        seed_load = 1'b1; seed_in = 16'h0000;
        step();
        seed_load = 1'b0;
        chk("t5_zero_seed", {16'b0, dut.lfsr}, 32'h0001);
        m_lfsr = 16'h0001;
        req = 2'b01; req_len0 = 8'd4;
        push_burst(1'b0, 4);
        step();
        seed_load = 1'b1; seed_in = 16'hACE1;
        step();
        seed_load = 1'b0;
        wait_done("t5_done", 2'b01);
        chk("t5_lfsr", {16'b0, dut.lfsr}, 32'h0010);
        step();
        req = 2'b00;
        step();

        // Test 6: reset mid-burst at count=5
        req = 2'b01; req_len0 = 8'd8; out_ready = 1'b1;
        push_burst(1'b0, 3);
        repeat (4) step();
        chk("t6_count", {24'b0, dut.count}, 32'd5);
        reset = 1'b1; out_ready = 1'b0;
        step();
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_done",  {30'b0, done},      32'd0);
        chk("t6_grant", {30'b0, grant},     32'd0);
        chk("t6_lfsr",  {16'b0, dut.lfsr},  32'h0001);
        reset = 1'b0; req = 2'b00; out_ready = 1'b1;
        step();
        chk("t6_no_done", {30'b0, done}, 32'd0);
        // rr_ptr must be back at 0: with both requesting, requester 0 wins first
        m_lfsr = 16'h0001;
        req = 2'b11; req_len0 = 8'd1; req_len1 = 8'd1;
        push_burst(1'b0, 1);
        push_burst(1'b1, 1);
        step();
        wait_done("t6_rr_a", 2'b01);
        wait_done("t6_rr_b", 2'b10);
        step();
        req = 2'b00;
        repeat (3) step();
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
